keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 146 ++++++++++++++
 tb/tb_keypad_emulator.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Emulates one key of a 4x4 matrix keypad: a press request closes the key's
// contact (with optional bounce) so the scanner sees its row drive looped back.
module keypad_emulator #(
   parameter int CNT_W   = 8,
   parameter int REL_CYC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       row,
   output logic [3:0]       col,
   input  logic [3:0]       key_code,
   input  logic             press_req,
   input  logic [CNT_W-1:0] hold_cycles,
   input  logic [CNT_W-1:0] bounce_cycles,
   output logic             busy,
   output logic             done,
   output logic [7:0]       hit_count
);

   typedef enum logic [2:0] {IDLE, BOUNCE, HOLD, RELEASE, DONE} state_t;

   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_CYC - 1);

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             contact, contact_d;
   logic [3:0]       key_q;
   logic [CNT_W-1:0] hold_q;
   logic [1:0]       r_idx, c_idx;
   logic             accept;
   logic             hit;

   // A zero hold still produces one closed cycle.
   function automatic logic [CNT_W-1:0] hold_last(input logic [CNT_W-1:0] h);
      return (h == '0) ? '0 : h - CNT_W'(1);
   endfunction

   assign accept = (state == IDLE) && press_req;
   assign busy   = (state == BOUNCE) || (state == HOLD) || (state == RELEASE);
   assign done   = (state == DONE);

   always_comb begin
      r_idx = 2'd0;
      c_idx = 2'd0;
      case (key_q)
         4'h1: begin r_idx = 2'd0; c_idx = 2'd0; end
         4'h2: begin r_idx = 2'd1; c_idx = 2'd0; end
         4'h3: begin r_idx = 2'd2; c_idx = 2'd0; end
         4'hA: begin r_idx = 2'd3; c_idx = 2'd0; end
         4'h4: begin r_idx = 2'd0; c_idx = 2'd1; end
         4'h5: begin r_idx = 2'd1; c_idx = 2'd1; end
         4'h6: begin r_idx = 2'd2; c_idx = 2'd1; end
         4'hB: begin r_idx = 2'd3; c_idx = 2'd1; end
         4'h7: begin r_idx = 2'd0; c_idx = 2'd2; end
         4'h8: begin r_idx = 2'd1; c_idx = 2'd2; end
         4'h9: begin r_idx = 2'd2; c_idx = 2'd2; end
         4'hC: begin r_idx = 2'd3; c_idx = 2'd2; end
         4'hE: begin r_idx = 2'd0; c_idx = 2'd3; end
         4'h0: begin r_idx = 2'd1; c_idx = 2'd3; end
         4'hF: begin r_idx = 2'd2; c_idx = 2'd3; end
         default: begin r_idx = 2'd3; c_idx = 2'd3; end
      endcase
   end

   // Contact loop-back is purely combinational so a scanning row is seen at once.
   assign hit = contact && !row[r_idx];

   always_comb begin
      col = 4'hF;
      if (hit) col[c_idx] = 1'b0;
   end

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      contact_d = contact;
      case (state)
         IDLE: begin
            if (press_req) begin
               contact_d = 1'b1;
               if (bounce_cycles != '0) begin
                  state_d = BOUNCE;
                  cnt_d   = bounce_cycles - CNT_W'(1);
               end else begin
                  state_d = HOLD;
                  cnt_d   = hold_last(hold_cycles);
               end
            end
         end
         BOUNCE: begin
            if (cnt == '0) begin
               state_d   = HOLD;
               cnt_d     = hold_last(hold_q);
               contact_d = 1'b1;
            end else begin
               cnt_d     = cnt - CNT_W'(1);
               contact_d = ~contact;
            end
         end
         HOLD: begin
            if (cnt == '0) begin
               state_d   = RELEASE;
               cnt_d     = REL_LAST;
               contact_d = 1'b0;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         RELEASE: begin
            if (cnt == '0) state_d = DONE;
            else           cnt_d   = cnt - CNT_W'(1);
         end
         DONE: state_d = IDLE;
         default: begin
            state_d   = IDLE;
            contact_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         contact   <= 1'b0;
         hit_count <= 8'd0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         contact <= contact_d;
         if (accept)
            hit_count <= 8'd0;
         else if (hit && (hit_count != 8'hFF))
            hit_count <= hit_count + 8'd1;
      end
   end

   // Press parameters are captured only on acceptance and stay fixed mid-press.
   always_ff @(posedge clk) begin
      if (accept) begin
         key_q  <= key_code;
         hold_q <= hold_cycles;
      end
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// Randomised bench for keypad_emulator: each press is predicted as a per-cycle
// contact list and compared cycle by cycle, including the scanner's decode.
module tb_keypad_emulator;

   localparam int REL = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] row = 4'hF;
   logic [3:0] col;
   logic [3:0] key_code = 4'h0;
   logic       press_req = 1'b0;
   logic [7:0] hold_cycles = 8'd0;
   logic [7:0] bounce_cycles = 8'd0;
   logic       busy;
   logic       done;
   logic [7:0] hit_count;

   int total = 0;
   int bad   = 0;

   // Keypad matrix position of each key code 0..F.
   int kr [16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 0, 2};
   int kc [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
   logic [3:0] scan_seq [5] = '{4'b0000, 4'b1110, 4'b1101, 4'b1011, 4'b0111};

   keypad_emulator #(.CNT_W(8), .REL_CYC(REL)) dut (
      .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code),
      .press_req(press_req), .hold_cycles(hold_cycles),
      .bounce_cycles(bounce_cycles), .busy(busy), .done(done),
      .hit_count(hit_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_col(input bit closed, input int key, input logic [3:0] r);
      logic [3:0] v;
      v = 4'hF;
      if (closed && (r[kr[key]] == 1'b0)) v[kc[key]] = 1'b0;
      return v;
   endfunction

   // Scanner's view: with exactly one row driven low, decode the sensed key.
   task automatic scan_check(input int key);
      int rr, cc, dec;
      rr = -1; cc = -1; dec = -1;
      if ($countones(~row) == 1 && $countones(~col) == 1) begin
         for (int i = 0; i < 4; i++) begin
            if (row[i] == 1'b0) rr = i;
            if (col[i] == 1'b0) cc = i;
         end
         for (int j = 0; j < 16; j++)
            if (kr[j] == rr && kc[j] == cc) dec = j;
         chk("scan_key", dec, key);
      end
   endtask

   // mode: 0 fixed row, 1 scanner loop, 2 random one-low/idle rows.
   // inj: cycle index at which a second request with key 9 is pulsed (-1 none).
   task automatic press(input int key, input int bnc, input int hld, input int mode,
                        input logic [3:0] rfix, input int inj);
      bit q[$];
      int hits;
      int n;
      bit closed;
      hits = 0;
      for (int i = 0; i < bnc; i++) q.push_back((i % 2) == 0);
      for (int i = 0; i < ((hld == 0) ? 1 : hld); i++) q.push_back(1'b1);
      for (int i = 0; i < REL; i++) q.push_back(1'b0);
      n = q.size();
      key_code      = 4'(key);
      bounce_cycles = 8'(bnc);
      hold_cycles   = 8'(hld);
      press_req     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      press_req = 1'b0;
      for (int k = 0; k <= n; k++) begin
         case (mode)
            0: row = rfix;
            1: row = scan_seq[k % 5];
            default: row = ($urandom_range(0, 3) == 0) ? 4'h0 : ~(4'b0001 << $urandom_range(0, 3));
         endcase
         if (k == inj) begin
            press_req = 1'b1;
            key_code  = 4'h9;
         end else if (k == inj + 1) begin
            press_req = 1'b0;
         end
         #1;
         closed = (k < n) ? q[k] : 1'b0;
         chk("col", col, exp_col(closed, key, row));
         chk("busy", busy, (k < n));
         chk("done", done, (k == n));
         scan_check(key);
         if (closed && row[kr[key]] == 1'b0 && hits < 255) hits++;
         @(negedge clk);
      end
      press_req = 1'b0;
      row = 4'h0;
      #1;
      chk("idle_col", col, 4'hF);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("hit_count", hit_count, hits);
   endtask

   task automatic reset_mid();
      key_code      = 4'hF;
      bounce_cycles = 8'd0;
      hold_cycles   = 8'd10;
      press_req     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      press_req = 1'b0;
      row = 4'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("pre_rst_col", col, 4'b0111);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      #1;
      chk("rst_col", col, 4'hF);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hits", hit_count, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk("post_rst_done", done, 0);
         chk("post_rst_col", col, 4'hF);
         @(negedge clk);
      end
   endtask

   initial begin
      row = 4'h0;
      press_req = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_col", col, 4'hF);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_hits", hit_count, 0);
      press_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("post_reset_busy", busy, 0);
      @(negedge clk);

      press(5, 0, 3, 0, 4'b1101, -1);
      press(1, 4, 2, 0, 4'b0000, -1);
      press(13, 0, 20, 1, 4'b0000, -1);
      press(7, 0, 6, 2, 4'h0, 2);
      reset_mid();
      press(0, 0, 0, 0, 4'b0000, -1);
      press(4, 3, 255, 0, 4'b0000, -1);
      press(2, 1, 2, 2, 4'h0, 1 + 2 + REL);
      for (int t = 0; t < 10; t++)
         press($urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 6), 2, 4'h0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
